// File: rtl/axi_lite_sync_mc_fifo_if.sv
// AXI4-Lite slave bus bundle for the multi-channel FIFO.
// The slave modport faces the FIFO; the master modport faces the bus driver.
interface axi_lite_sync_mc_fifo_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_sync_mc_fifo.sv
// NUM_CH independent single-clock FIFOs behind one AXI4-Lite slave, each with
// its own peripheral pop port, exact occupancy counters and per-channel flags.
module axi_lite_sync_mc_fifo #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int NUM_CH       = 4,
  parameter int AFULL_THRESH = FIFO_DEPTH - 2
) (
  input  logic                           clk_axi,
  input  logic                           axi_reset_i,
  axi_lite_sync_mc_fifo_if.slave         axi_s,
  input  logic [NUM_CH-1:0]              periph_rd_en_i,
  output logic [NUM_CH*DATA_WIDTH-1:0]   periph_rdata_o,
  output logic [NUM_CH-1:0]              periph_rvalid_o,
  output logic [NUM_CH-1:0]              periph_empty_o,
  output logic [NUM_CH-1:0]              periph_full_o,
  output logic [NUM_CH-1:0]              periph_afull_o
);

  localparam int CHW  = ADDR_WIDTH - 4;
  localparam int PTR  = $clog2(FIFO_DEPTH);
  localparam int OCCW = PTR + 1;
  localparam logic [OCCW-1:0] DEPTH_W  = OCCW'(FIFO_DEPTH);
  localparam logic [OCCW-1:0] AFULL_W  = OCCW'(AFULL_THRESH);
  localparam logic [CHW:0]    NUM_CH_W = (CHW+1)'(NUM_CH);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [PTR-1:0]        wptr_q [NUM_CH];
  logic [PTR-1:0]        wptr_d [NUM_CH];
  logic [PTR-1:0]        rptr_q [NUM_CH];
  logic [PTR-1:0]        rptr_d [NUM_CH];
  logic [OCCW-1:0]       occ_q  [NUM_CH];
  logic [OCCW-1:0]       occ_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] prdata_q [NUM_CH];
  logic [DATA_WIDTH-1:0] prdata_d [NUM_CH];
  logic [NUM_CH-1:0]     ovf_q, ovf_d, empty_q, empty_d, full_q, full_d, afull_q, afull_d;
  logic [NUM_CH-1:0]     prvalid_q, prvalid_d;
  logic [NUM_CH-1:0]     push, apop, ppop, flush, clr_ovf, ovf_hit;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_strb;
  logic [CHW-1:0]        wr_ch, rd_ch;
  logic [1:0]            wr_reg, rd_reg;
  logic                  wr_ch_ok, rd_ch_ok, wr_err;
  logic [OCCW-1:0]       wr_occ, rd_occ;
  logic [DATA_WIDTH-1:0] rd_head, rd_status;
  logic                  unused_addr_bits;

  assign axi_s.awready = !aw_held_q && !bvalid_q && !axi_reset_i;
  assign axi_s.wready  = !w_held_q && !bvalid_q && !axi_reset_i;
  assign axi_s.arready = !rvalid_q && !axi_reset_i;
  assign axi_s.bvalid  = bvalid_q;
  assign axi_s.bresp   = bresp_q;
  assign axi_s.rvalid  = rvalid_q;
  assign axi_s.rresp   = rresp_q;
  assign axi_s.rdata   = rdata_q;

  assign aw_hs  = axi_s.awvalid && axi_s.awready;
  assign w_hs   = axi_s.wvalid && axi_s.wready;
  assign ar_hs  = axi_s.arvalid && axi_s.arready;
  // Whichever half arrives second (or both together) completes the write.
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_addr  = aw_held_q ? aw_addr_q : axi_s.awaddr;
  assign wr_data  = w_held_q ? w_data_q : axi_s.wdata;
  assign wr_strb  = w_held_q ? w_strb_q : axi_s.wstrb;
  assign wr_ch    = wr_addr[ADDR_WIDTH-1:4];
  assign wr_reg   = wr_addr[3:2];
  assign rd_ch    = axi_s.araddr[ADDR_WIDTH-1:4];
  assign rd_reg   = axi_s.araddr[3:2];
  assign wr_ch_ok = {1'b0, wr_ch} < NUM_CH_W;
  assign rd_ch_ok = {1'b0, rd_ch} < NUM_CH_W;
  assign unused_addr_bits = ^{wr_addr[1:0], axi_s.araddr[1:0]};

  always_comb begin
    wr_occ    = '0;
    rd_occ    = '0;
    rd_head   = '0;
    rd_status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CHW'(c)) wr_occ = occ_q[c];
      if (rd_ch == CHW'(c)) begin
        rd_occ    = occ_q[c];
        rd_head   = mem_q[c][rptr_q[c]];
        rd_status = {16'b0, 8'(occ_q[c]), 4'b0, ovf_q[c], afull_q[c], full_q[c], empty_q[c]};
      end
    end
  end

  always_comb begin
    wr_err = 1'b1;
    if (wr_ch_ok) begin
      case (wr_reg)
        2'd0:    wr_err = (wr_strb != 4'hF) || (wr_occ == DEPTH_W);
        2'd3:    wr_err = 1'b0;
        default: wr_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (bvalid_q && axi_s.bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = axi_s.awaddr;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = axi_s.wdata;
        w_strb_d = axi_s.wstrb;
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && axi_s.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      if (rd_ch_ok) begin
        case (rd_reg)
          2'd0, 2'd2: begin
            if (rd_occ != '0) begin
              rdata_d = rd_head;
              rresp_d = RESP_OKAY;
            end
          end
          2'd1:    begin rdata_d = rd_status; rresp_d = RESP_OKAY; end
          default: rresp_d = RESP_OKAY;
        endcase
      end
    end
  end

  // Per-channel arbitration: flush beats everything, AXI pop beats periph pop.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      push[c]    = commit && wr_ch == CHW'(c) && wr_reg == 2'd0 && wr_strb == 4'hF
                   && occ_q[c] != DEPTH_W;
      ovf_hit[c] = commit && wr_ch == CHW'(c) && wr_reg == 2'd0 && wr_strb == 4'hF
                   && occ_q[c] == DEPTH_W;
      flush[c]   = commit && wr_ch == CHW'(c) && wr_reg == 2'd3 && wr_data[0];
      clr_ovf[c] = commit && wr_ch == CHW'(c) && wr_reg == 2'd3 && wr_data[1];
      apop[c]    = ar_hs && rd_ch == CHW'(c) && rd_reg == 2'd0 && occ_q[c] != '0;
      ppop[c]    = periph_rd_en_i[c] && occ_q[c] != '0 && !apop[c] && !flush[c];

      wptr_d[c]    = wptr_q[c] + PTR'(push[c]);
      rptr_d[c]    = rptr_q[c] + PTR'(apop[c] || ppop[c]);
      occ_d[c]     = occ_q[c] + OCCW'(push[c]) - OCCW'(apop[c] || ppop[c]);
      ovf_d[c]     = (ovf_q[c] || ovf_hit[c]) && !clr_ovf[c];
      prvalid_d[c] = ppop[c];
      prdata_d[c]  = ppop[c] ? mem_q[c][rptr_q[c]] : prdata_q[c];
      if (flush[c]) begin
        wptr_d[c] = '0;
        rptr_d[c] = '0;
        occ_d[c]  = '0;
        ovf_d[c]  = 1'b0;
      end
      empty_d[c] = occ_d[c] == '0;
      full_d[c]  = occ_d[c] == DEPTH_W;
      afull_d[c] = occ_d[c] >= AFULL_W;
    end
  end

  always_ff @(posedge clk_axi) begin
    if (axi_reset_i) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      ovf_q     <= '0;
      empty_q   <= '1;
      full_q    <= '0;
      afull_q   <= '0;
      prvalid_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]   <= '0;
        rptr_q[c]   <= '0;
        occ_q[c]    <= '0;
        prdata_q[c] <= '0;
      end
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      prvalid_q <= prvalid_d;
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]   <= wptr_d[c];
        rptr_q[c]   <= rptr_d[c];
        occ_q[c]    <= occ_d[c];
        prdata_q[c] <= prdata_d[c];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_axi) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_periph
    assign periph_rdata_o[g*DATA_WIDTH +: DATA_WIDTH] = prdata_q[g];
  end

  assign periph_rvalid_o = prvalid_q;
  assign periph_empty_o  = empty_q;
  assign periph_full_o   = full_q;
  assign periph_afull_o  = afull_q;

endmodule

// File: tb/tb_axi_lite_sync_mc_fifo.sv
// Self-checking bench for axi_lite_sync_mc_fifo: a vector table of AXI accesses
// plus hand-written multi-cycle sequences, all checked through response queues.
module tb_axi_lite_sync_mc_fifo;

  localparam int NCH  = 4;
  localparam int NVEC = 22;

  typedef struct {
    logic        isWrite;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  expResp;
    logic [31:0] expData;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } pexp_t;

  logic              clock;
  logic              reset;
  logic [NCH-1:0]    periphRdEn;
  logic [NCH*32-1:0] periphRdata;
  logic [NCH-1:0]    periphRvalid, periphEmpty, periphFull, periphAfull;

  int checks;
  int failures;

  logic [1:0] bQ[$];
  rexp_t      rQ[$];
  pexp_t      pQ[$];
  vec_t       vecs [NVEC];

  axi_lite_sync_mc_fifo_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_lite_sync_mc_fifo #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4), .NUM_CH(NCH), .AFULL_THRESH(2)
  ) dut (
    .clk_axi(clock),
    .axi_reset_i(reset),
    .axi_s(bus),
    .periph_rd_en_i(periphRdEn),
    .periph_rdata_o(periphRdata),
    .periph_rvalid_o(periphRvalid),
    .periph_empty_o(periphEmpty),
    .periph_full_o(periphFull),
    .periph_afull_o(periphAfull)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard side: responses are compared at the negedge where they are accepted.
  always @(negedge clock) begin
    if (bus.bvalid && bus.bready) begin
      if (bQ.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL b_unexpected actual=bresp %b expected=no response", bus.bresp);
      end else begin
        checkOutput("b_resp", 32'(bus.bresp), 32'(bQ.pop_front()));
      end
    end
    if (bus.rvalid && bus.rready) begin
      if (rQ.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL r_unexpected actual=rdata %h expected=no response", bus.rdata);
      end else begin
        rexp_t re;
        re = rQ.pop_front();
        checkOutput("r_data", bus.rdata, re.data);
        checkOutput("r_resp", 32'(bus.rresp), 32'(re.resp));
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (periphRvalid[c]) begin
        if (pQ.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL periph_unexpected actual=ch%0d data %h expected=no pulse",
                   c, periphRdata[c*32 +: 32]);
        end else begin
          pexp_t pe;
          pe = pQ.pop_front();
          checkOutput("periph_ch", 32'(c), 32'(pe.ch));
          checkOutput("periph_data", periphRdata[c*32 +: 32], pe.data);
        end
      end
    end
  end

  task automatic axiWrite(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] expResp);
    logic awDone, wDone, awHs, wHs;
    bQ.push_back(expResp);
    @(negedge clock);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    awDone = 1'b0;
    wDone  = 1'b0;
    for (int n = 0; n < 32 && !(awDone && wDone); n++) begin
      awHs = bus.awvalid && bus.awready;
      wHs  = bus.wvalid && bus.wready;
      @(negedge clock);
      if (awHs) begin bus.awvalid = 1'b0; awDone = 1'b1; end
      if (wHs)  begin bus.wvalid  = 1'b0; wDone  = 1'b1; end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    checkOutput("wr_handshake", 32'({awDone, wDone}), 32'h3);
  endtask

  task automatic axiRead(input logic [7:0] addr, input logic [31:0] expData, input logic [1:0] expResp);
    logic arDone, arHs;
    rexp_t re;
    re.resp = expResp;
    re.data = expData;
    rQ.push_back(re);
    @(negedge clock);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    arDone = 1'b0;
    for (int n = 0; n < 32 && !arDone; n++) begin
      arHs = bus.arvalid && bus.arready;
      @(negedge clock);
      if (arHs) begin bus.arvalid = 1'b0; arDone = 1'b1; end
    end
    bus.arvalid = 1'b0;
    checkOutput("ar_handshake", 32'(arDone), 32'h1);
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 50; n++) begin
      if (bQ.size() == 0 && rQ.size() == 0) break;
      @(negedge clock);
    end
    checkOutput("resp_timeout", 32'(bQ.size() + rQ.size()), 32'h0);
    bQ.delete();
    rQ.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isWrite) axiWrite(v.addr, v.data, v.strb, v.expResp);
    else           axiRead(v.addr, v.expData, v.expResp);
    waitIdle();
  endtask

  task automatic periphDrain(input int ch, input int cycles);
    @(negedge clock);
    periphRdEn[ch] = 1'b1;
    repeat (cycles) @(negedge clock);
    periphRdEn[ch] = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("periph_drain", 32'(pQ.size()), 32'h0);
    pQ.delete();
  endtask

  initial begin
    pexp_t pe;
    rexp_t re;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 8'h14, 32'h0,        4'h0, 2'b00, 32'h00000100};
    vecs[1]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b10, 32'h00000000};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b10, 32'h00000000};
    vecs[3]  = '{1'b1, 8'h30, 32'h0000DEAD, 4'h3, 2'b10, 32'h0};
    vecs[4]  = '{1'b0, 8'h34, 32'h0,        4'h0, 2'b00, 32'h00000001};
    vecs[5]  = '{1'b1, 8'h50, 32'h12345678, 4'hF, 2'b10, 32'h0};
    vecs[6]  = '{1'b0, 8'h50, 32'h0,        4'h0, 2'b10, 32'h00000000};
    vecs[7]  = '{1'b1, 8'h04, 32'h11111111, 4'hF, 2'b10, 32'h0};
    vecs[8]  = '{1'b1, 8'h20, 32'h00000077, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 8'h28, 32'h0,        4'h0, 2'b00, 32'h00000077};
    vecs[10] = '{1'b0, 8'h28, 32'h0,        4'h0, 2'b00, 32'h00000077};
    vecs[11] = '{1'b0, 8'h24, 32'h0,        4'h0, 2'b00, 32'h00000100};
    vecs[12] = '{1'b0, 8'h20, 32'h0,        4'h0, 2'b00, 32'h00000077};
    vecs[13] = '{1'b0, 8'h24, 32'h0,        4'h0, 2'b00, 32'h00000001};
    vecs[14] = '{1'b1, 8'h00, 32'h00000001, 4'hF, 2'b00, 32'h0};
    vecs[15] = '{1'b1, 8'h00, 32'h00000002, 4'hF, 2'b00, 32'h0};
    vecs[16] = '{1'b1, 8'h00, 32'h00000003, 4'hF, 2'b00, 32'h0};
    vecs[17] = '{1'b1, 8'h00, 32'h00000004, 4'hF, 2'b00, 32'h0};
    vecs[18] = '{1'b1, 8'h00, 32'h00000005, 4'hF, 2'b10, 32'h0};
    vecs[19] = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h0000040E};
    vecs[20] = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h00000000};
    vecs[21] = '{1'b1, 8'h08, 32'h22222222, 4'hF, 2'b10, 32'h0};

    reset       = 1'b1;
    periphRdEn  = '0;
    bus.awaddr  = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready  = 1'b1;
    bus.araddr  = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b1;

    repeat (3) @(negedge clock);
    checkOutput("rst_awready_low", 32'(bus.awready), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_empty", 32'(periphEmpty), 32'hF);
    checkOutput("rst_full", 32'(periphFull), 32'h0);
    checkOutput("rst_afull", 32'(periphAfull), 32'h0);
    checkOutput("rst_bvalid", 32'(bus.bvalid), 32'h0);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("rst_prvalid", 32'(periphRvalid), 32'h0);
    checkOutput("rst_awready", 32'(bus.awready), 32'h1);
    checkOutput("rst_arready", 32'(bus.arready), 32'h1);

    // AW first, W one cycle later: response appears right after the W handshake.
    bQ.push_back(2'b00);
    bus.awaddr  = 8'h10;
    bus.awvalid = 1'b1;
    @(negedge clock);
    bus.awvalid = 1'b0;
    bus.wdata   = 32'hA5A50001;
    bus.wstrb   = 4'hF;
    bus.wvalid  = 1'b1;
    checkOutput("split_bvalid_early", 32'(bus.bvalid), 32'h0);
    @(negedge clock);
    bus.wvalid = 1'b0;
    checkOutput("split_bvalid", 32'(bus.bvalid), 32'h1);
    waitIdle();

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);

    checkOutput("ch0_full", 32'(periphFull[0]), 32'h1);
    checkOutput("ch0_afull", 32'(periphAfull[0]), 32'h1);
    checkOutput("ch0_empty_when_full", 32'(periphEmpty[0]), 32'h0);

    pe.ch = 1; pe.data = 32'hA5A50001; pQ.push_back(pe);
    periphDrain(1, 3);
    checkOutput("ch1_empty_after_pop", 32'(periphEmpty[1]), 32'h1);

    for (int i = 1; i <= 4; i++) begin
      pe.ch = 0; pe.data = 32'(i); pQ.push_back(pe);
    end
    periphDrain(0, 6);
    checkOutput("ch0_empty_after_pops", 32'(periphEmpty[0]), 32'h1);
    checkOutput("ch0_full_after_pops", 32'(periphFull[0]), 32'h0);
    axiRead(8'h04, 32'h00000009, 2'b00);
    waitIdle();

    // Push/pop pairs through ch2 cross the pointer wrap several times.
    @(negedge clock);
    periphRdEn[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pe.ch = 2; pe.data = 32'h100 + 32'(i); pQ.push_back(pe);
      axiWrite(8'h20, 32'h100 + 32'(i), 4'hF, 2'b00);
      waitIdle();
    end
    repeat (3) @(negedge clock);
    periphRdEn[2] = 1'b0;
    @(negedge clock);
    checkOutput("ch2_wrap_drain", 32'(pQ.size()), 32'h0);
    checkOutput("ch2_empty", 32'(periphEmpty[2]), 32'h1);
    pQ.delete();

    // AXI pop and peripheral pop collide on ch3: AXI takes the head.
    axiWrite(8'h30, 32'h30, 4'hF, 2'b00);
    waitIdle();
    axiWrite(8'h30, 32'h31, 4'hF, 2'b00);
    waitIdle();
    @(negedge clock);
    re.resp = 2'b00; re.data = 32'h30; rQ.push_back(re);
    pe.ch = 3; pe.data = 32'h31; pQ.push_back(pe);
    checkOutput("ch3_arready", 32'(bus.arready), 32'h1);
    bus.araddr    = 8'h30;
    bus.arvalid   = 1'b1;
    periphRdEn[3] = 1'b1;
    @(negedge clock);
    bus.arvalid = 1'b0;
    checkOutput("ch3_prvalid_arb", 32'(periphRvalid[3]), 32'h0);
    @(negedge clock);
    checkOutput("ch3_prvalid_retry", 32'(periphRvalid[3]), 32'h1);
    periphRdEn[3] = 1'b0;
    waitIdle();
    repeat (2) @(negedge clock);
    checkOutput("ch3_drain", 32'(pQ.size()), 32'h0);
    pQ.delete();

    // Three entries with overflow still latched, then flush.
    axiWrite(8'h00, 32'hA, 4'hF, 2'b00); waitIdle();
    axiWrite(8'h00, 32'hB, 4'hF, 2'b00); waitIdle();
    axiWrite(8'h00, 32'hC, 4'hF, 2'b00); waitIdle();
    axiRead(8'h04, 32'h0000030C, 2'b00); waitIdle();
    axiWrite(8'h0C, 32'h1, 4'hF, 2'b00); waitIdle();
    axiRead(8'h04, 32'h00000001, 2'b00); waitIdle();

    // Reset while a write response is still pending.
    @(negedge clock);
    bus.bready  = 1'b0;
    bus.awaddr  = 8'h00; bus.awvalid = 1'b1;
    bus.wdata   = 32'h99; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clock);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    checkOutput("rst_bvalid_pending", 32'(bus.bvalid), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst2_bvalid", 32'(bus.bvalid), 32'h0);
    checkOutput("rst2_awready", 32'(bus.awready), 32'h0);
    checkOutput("rst2_wready", 32'(bus.wready), 32'h0);
    checkOutput("rst2_arready", 32'(bus.arready), 32'h0);
    checkOutput("rst2_empty", 32'(periphEmpty), 32'hF);
    checkOutput("rst2_full", 32'(periphFull), 32'h0);
    checkOutput("rst2_afull", 32'(periphAfull), 32'h0);
    checkOutput("rst2_prvalid", 32'(periphRvalid), 32'h0);
    reset      = 1'b0;
    bus.bready = 1'b1;
    @(negedge clock);
    checkOutput("rst2_awready_after", 32'(bus.awready), 32'h1);
    checkOutput("rst2_bvalid_after", 32'(bus.bvalid), 32'h0);
    axiRead(8'h04, 32'h00000001, 2'b00);
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
